seq_add_controller: RTL and testbench

Multi-cycle add/subtract controller that time-shares one SLICE-bit carry-lookahead adder slice across a WIDTH-bit operation. The slice is built from the team's 4-bit CLA groups and Level-1 lookahead carry unit. The block processes the operation LSB-slice first and carries the slice carry-out into the next cycle. It sits beside the ALU as the area-reduced adder path, with a start/ready/done handshake to the surrounding control.

---
 rtl/seq_add_controller.sv | 170 +++++++++++++++++
 tb/tb_seq_add_controller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_add_controller.sv
// ============================================================================
//  Module      : seq_add_controller
//  Description : Multi-cycle WIDTH-bit add/subtract on one time-shared
//                SLICE-bit carry-lookahead slice, LSB slice first.
//                Optional macro SEQ_ADD_SUB_EN enables subtraction.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_add_controller #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int NS    = WIDTH / SLICE;
    localparam int NG    = SLICE / 4;
    localparam int IDX_W = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [IDX_W-1:0] c_LAST = IDX_W'(NS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_op_a, r_op_b, r_acc, r_sum;
    logic [IDX_W-1:0]   r_idx;
    logic               r_cr, r_ready, r_done, r_c_out, r_ovf, r_zero;

    logic               w_sub;
    logic [SLICE-1:0]   w_sa, w_sb, w_g, w_p, w_sum_slice;
    logic [NG-1:0]      w_grp_g, w_grp_p;
    logic [NG:0]        w_gc;
    logic [WIDTH-1:0]   w_acc_next;
    logic               w_last;

`ifdef SEQ_ADD_SUB_EN
    assign w_sub = sub;
`else
    // Port kept for drop-in compatibility; its value never reaches the datapath.
    assign w_sub = sub & 1'b0;
`endif

    assign w_sa = r_op_a[int'(r_idx)*SLICE +: SLICE];
    assign w_sb = r_op_b[int'(r_idx)*SLICE +: SLICE];
    assign w_g  = w_sa & w_sb;
    assign w_p  = w_sa ^ w_sb;

    generate
        for (genvar j = 0; j < NG; j++) begin : g_grp
            logic [3:0] w_bg, w_bp, w_bc;
            assign w_bg = w_g[4*j +: 4];
            assign w_bp = w_p[4*j +: 4];
            assign w_bc[0] = w_gc[j];
            assign w_bc[1] = w_bg[0] | (w_bp[0] & w_gc[j]);
            assign w_bc[2] = w_bg[1] | (w_bp[1] & w_bg[0]) | (&w_bp[1:0] & w_gc[j]);
            assign w_bc[3] = w_bg[2] | (w_bp[2] & w_bg[1]) | (&w_bp[2:1] & w_bg[0])
                           | (&w_bp[2:0] & w_gc[j]);
            assign w_grp_g[j] = w_bg[3] | (w_bp[3] & w_bg[2]) | (&w_bp[3:2] & w_bg[1])
                              | (&w_bp[3:1] & w_bg[0]);
            assign w_grp_p[j] = &w_bp;
            assign w_sum_slice[4*j +: 4] = w_bp ^ w_bc;
        end
    endgenerate

    // Level-1 lookahead: each group carry as a flat sum of products of group G/P.
    always_comb begin : p_lookahead
        logic v_or, v_prop;
        w_gc    = '0;
        w_gc[0] = r_cr;
        v_or    = 1'b0;
        v_prop  = 1'b0;
        for (int j = 0; j < NG; j++) begin
            v_or = 1'b0;
            for (int k = 0; k <= j; k++) begin
                v_prop = w_grp_g[k];
                for (int m = k + 1; m <= j; m++) v_prop = v_prop & w_grp_p[m];
                v_or = v_or | v_prop;
            end
            v_prop = r_cr;
            for (int m = 0; m <= j; m++) v_prop = v_prop & w_grp_p[m];
            w_gc[j+1] = v_or | v_prop;
        end
    end

    always_comb begin
        w_acc_next = r_acc;
        w_acc_next[int'(r_idx)*SLICE +: SLICE] = w_sum_slice;
    end

    assign w_last = (r_idx == c_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
            r_acc   <= '0;
            r_idx   <= '0;
            r_cr    <= 1'b0;
            r_op_a  <= '0;
            r_op_b  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_op_a  <= a;
                        r_op_b  <= w_sub ? ~b : b;
                        r_cr    <= w_sub;
                        r_idx   <= '0;
                        r_ready <= 1'b0;
                        r_state <= S_RUN;
                    end else begin
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_next;
                    r_cr  <= w_gc[NG];
                    r_idx <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                        r_sum   <= w_acc_next;
                        r_c_out <= w_gc[NG];
                        r_ovf   <= (r_op_a[WIDTH-1] == r_op_b[WIDTH-1])
                                 & (w_acc_next[WIDTH-1] != r_op_a[WIDTH-1]);
                        r_zero  <= (w_acc_next == '0);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign ready = r_ready;
    assign done  = r_done;
    assign sum   = r_sum;
    assign c_out = r_c_out;
    assign ovf   = r_ovf;
    assign zero  = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_seq_add_controller.sv
// ============================================================================
//  Module      : tb_seq_add_controller
//  Description : Directed self-checking bench for seq_add_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_add_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        sub = 1'b0;
    logic        ready, done, c_out, ovf, zero;
    logic [31:0] sum;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_add_controller #(.WIDTH(32), .SLICE(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .sub(sub),
        .ready(ready), .done(done), .sum(sum), .c_out(c_out), .ovf(ovf), .zero(zero)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accepts one operation from IDLE/DONE and waits for done; lat = 99 on timeout.
    task automatic do_op(input logic [31:0] va, input logic [31:0] vb,
                         input logic vsub, output int lat, output logic busy_seen);
        a = va; b = vb; sub = vsub; start = 1'b1;
        step();
        start = 1'b0;
        busy_seen = ~ready;
        lat = 99;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({ready, done, c_out, ovf, zero} !== 5'b10000 || sum !== 32'h0) begin
            errors++;
            $display("FAIL reset: ready=%b done=%b sum=%h c=%b ovf=%b z=%b, want 1 0 0 0 0 0",
                     ready, done, sum, c_out, ovf, zero);
        end
    endtask

    task automatic test_add();
        int lat; logic busy;
        do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, lat, busy);
        checks++;
        if (lat !== 4 || busy !== 1'b1) begin
            errors++; $display("FAIL add_latency: lat=%0d busy=%b, want 4 1", lat, busy);
        end
        checks++;
        if (sum !== 32'h0000_0100 || {c_out, ovf, zero} !== 3'b000) begin
            errors++; $display("FAIL add_result: sum=%h c/o/z=%b%b%b, want 00000100 000",
                               sum, c_out, ovf, zero);
        end
        step();
        checks++;
        if (done !== 1'b0 || ready !== 1'b1) begin
            errors++; $display("FAIL add_done_pulse: done=%b ready=%b, want 0 1", done, ready);
        end
    endtask

    task automatic test_wrap();
        int lat; logic busy;
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat, busy);
        checks++;
        if (lat !== 4 || sum !== 32'h0 || {c_out, ovf, zero} !== 3'b101) begin
            errors++; $display("FAIL wrap: lat=%0d sum=%h c/o/z=%b%b%b, want 4 00000000 101",
                               lat, sum, c_out, ovf, zero);
        end
        step();
    endtask

    task automatic test_overflow();
        int lat; logic busy;
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat, busy);
        checks++;
        if (lat !== 4 || sum !== 32'h8000_0000 || {c_out, ovf, zero} !== 3'b010) begin
            errors++; $display("FAIL overflow: lat=%0d sum=%h c/o/z=%b%b%b, want 4 80000000 010",
                               lat, sum, c_out, ovf, zero);
        end
        step();
    endtask

    task automatic test_subtract();
        int lat; logic busy;
        logic [31:0] exp_sum;
`ifdef SEQ_ADD_SUB_EN
        exp_sum = 32'hFFFF_FFFE;
`else
        exp_sum = 32'h0000_000C;
`endif
        do_op(32'd5, 32'd7, 1'b1, lat, busy);
        checks++;
        if (lat !== 4 || sum !== exp_sum || {c_out, ovf, zero} !== 3'b000) begin
            errors++; $display("FAIL subtract: lat=%0d sum=%h c/o/z=%b%b%b, want 4 %h 000",
                               lat, sum, c_out, ovf, zero, exp_sum);
        end
        step();
    endtask

    task automatic test_reset_mid_run();
        int pulses;
        a = 32'd1; b = 32'd1; sub = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        checks++;
        if (ready !== 1'b0 || sum !== 32'h0000_000C && sum !== 32'hFFFF_FFFE) begin
            errors++; $display("FAIL mid_run_hold: ready=%b sum=%h, want 0 and previous result",
                               ready, sum);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (ready !== 1'b1 || done !== 1'b0 || sum !== 32'h0 || zero !== 1'b0) begin
            errors++; $display("FAIL mid_run_reset: ready=%b done=%b sum=%h zero=%b, want 1 0 0 0",
                               ready, done, sum, zero);
        end
        pulses = 0;
        for (int n = 0; n < 8; n++) begin
            step();
            if (done) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++; $display("FAIL mid_run_no_done: pulses=%0d, want 0", pulses);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        a = 32'd10; b = 32'd20; sub = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        a = 32'd100; b = 32'd100; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (ready !== 1'b0) begin
            errors++; $display("FAIL busy_ready: ready=%b, want 0", ready);
        end
        step();
        step();
        checks++;
        if (done !== 1'b1 || sum !== 32'd30) begin
            errors++; $display("FAIL busy_ignored: done=%b sum=%0d, want 1 30", done, sum);
        end
        a = 32'd2; b = 32'd3; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (ready !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL b2b_accept: ready=%b done=%b, want 0 0", ready, done);
        end
        lat = 99;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (done) begin
                lat = n;
                break;
            end
        end
        checks++;
        if (lat !== 4 || sum !== 32'd5) begin
            errors++; $display("FAIL b2b_result: lat=%0d sum=%0d, want 4 5", lat, sum);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_add();
        test_wrap();
        test_overflow();
        test_subtract();
        test_reset_mid_run();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
